// File: rtl/game_ctrl_if.sv
// Signal bundle between the game sequencer and the rest of the endless-runner top level.
// The slave modport is the controller's view; master is the surrounding logic.
interface game_ctrl_if #(
  parameter int LIVES        = 3,
  parameter int SPEED_LEVELS = 4
);
  localparam int LIVES_W = $clog2(LIVES + 1);
  localparam int SPEED_W = $clog2(SPEED_LEVELS);

  logic               start_i;
  logic               pause_i;
  logic               next_frame_i;
  logic               collide_i;
  logic [15:0]        rand_i;
  logic [2:0]         state_o;
  logic               title_en_o;
  logic               lfsr_next_o;
  logic               score_en_o;
  logic               score_clr_o;
  logic               bird_spawn_o;
  logic               cactus_spawn_o;
  logic               hit_o;
  logic [LIVES_W-1:0] lives_o;
  logic [SPEED_W-1:0] speed_o;

  modport master (
    output start_i, pause_i, next_frame_i, collide_i, rand_i,
    input  state_o, title_en_o, lfsr_next_o, score_en_o, score_clr_o,
           bird_spawn_o, cactus_spawn_o, hit_o, lives_o, speed_o
  );

  modport slave (
    input  start_i, pause_i, next_frame_i, collide_i, rand_i,
    output state_o, title_en_o, lfsr_next_o, score_en_o, score_clr_o,
           bird_spawn_o, cactus_spawn_o, hit_o, lives_o, speed_o
  );
endinterface

// File: rtl/game_ctrl.sv
// Five-state game sequencer: lives, pause, post-hit invulnerability, score pacing,
// speed levels and obstacle spawn decisions.
module game_ctrl #(
  parameter int LIVES         = 3,
  parameter int INVULN_FRAMES = 60,
  parameter int SCORE_DIV     = 6,
  parameter int LEVEL_TICKS   = 100,
  parameter int SPEED_LEVELS  = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  game_ctrl_if.slave  bus
);
  localparam int LIVES_W = $clog2(LIVES + 1);
  localparam int SPEED_W = $clog2(SPEED_LEVELS);
  localparam int FRAME_W = (SCORE_DIV > 1) ? $clog2(SCORE_DIV) : 1;
  localparam int TICK_W  = (LEVEL_TICKS > 1) ? $clog2(LEVEL_TICKS) : 1;
  localparam int INV_W   = (INVULN_FRAMES > 1) ? $clog2(INVULN_FRAMES) : 1;

  typedef enum logic [2:0] {
    ST_STARTING  = 3'd0,
    ST_PLAYING   = 3'd1,
    ST_PAUSED    = 3'd2,
    ST_HIT       = 3'd3,
    ST_GAME_OVER = 3'd4
  } state_t;

  state_t             state_q, state_d;
  state_t             ret_q, ret_d;
  logic [LIVES_W-1:0] lives_q, lives_d;
  logic [SPEED_W-1:0] speed_q, speed_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic [TICK_W-1:0]  tick_q, tick_d;
  logic [INV_W-1:0]   inv_q, inv_d;
  logic               start_prev_q, start_prev_d;
  logic               pause_prev_q, pause_prev_d;
  logic               score_en_q, score_en_d;
  logic               score_clr_q, score_clr_d;
  logic               bird_q, bird_d;
  logic               cactus_q, cactus_d;

  logic start_edge, pause_edge, adv_frame;
  logic cactus_cond, bird_cond;
  logic unused_rand;

  assign start_edge  = bus.start_i & ~start_prev_q;
  assign pause_edge  = bus.pause_i & ~pause_prev_q;
  assign cactus_cond = (bus.rand_i[12:7] == 6'b101010);
  assign bird_cond   = (bus.rand_i[12:8] == 5'd0) && (speed_q != '0);
  assign unused_rand = ^{bus.rand_i[15:13], bus.rand_i[6:0]};

  always_comb begin
    state_d      = state_q;
    ret_d        = ret_q;
    lives_d      = lives_q;
    speed_d      = speed_q;
    frame_d      = frame_q;
    tick_d       = tick_q;
    inv_d        = inv_q;
    start_prev_d = bus.start_i;
    pause_prev_d = bus.pause_i;
    score_en_d   = 1'b0;
    score_clr_d  = 1'b0;
    bird_d       = 1'b0;
    cactus_d     = 1'b0;
    adv_frame    = 1'b0;

    case (state_q)
      ST_STARTING, ST_GAME_OVER: begin
        if (start_edge) begin
          state_d     = ST_PLAYING;
          score_clr_d = 1'b1;
          lives_d     = LIVES_W'(LIVES);
          speed_d     = '0;
          frame_d     = '0;
          tick_d      = '0;
          inv_d       = '0;
        end
      end
      ST_PLAYING: begin
        // Collision and pause both discard the frame arriving in the same cycle.
        if (bus.collide_i) begin
          if (lives_q > LIVES_W'(1)) begin
            lives_d = lives_q - LIVES_W'(1);
            inv_d   = '0;
            state_d = ST_HIT;
          end else begin
            lives_d = '0;
            state_d = ST_GAME_OVER;
          end
        end else if (pause_edge) begin
          ret_d   = ST_PLAYING;
          state_d = ST_PAUSED;
        end else if (bus.next_frame_i) begin
          adv_frame = 1'b1;
        end
      end
      ST_HIT: begin
        if (pause_edge) begin
          ret_d   = ST_HIT;
          state_d = ST_PAUSED;
        end else if (bus.next_frame_i) begin
          adv_frame = 1'b1;
          if (inv_q == INV_W'(INVULN_FRAMES - 1)) begin
            inv_d   = '0;
            state_d = ST_PLAYING;
          end else begin
            inv_d = inv_q + INV_W'(1);
          end
        end
      end
      ST_PAUSED: begin
        if (pause_edge) state_d = ret_q;
      end
      default: state_d = ST_STARTING;
    endcase

    if (adv_frame) begin
      if (frame_q == FRAME_W'(SCORE_DIV - 1)) begin
        frame_d    = '0;
        score_en_d = 1'b1;
        if (tick_q == TICK_W'(LEVEL_TICKS - 1)) begin
          tick_d = '0;
          if (speed_q != SPEED_W'(SPEED_LEVELS - 1)) speed_d = speed_q + SPEED_W'(1);
        end else begin
          tick_d = tick_q + TICK_W'(1);
        end
      end else begin
        frame_d = frame_q + FRAME_W'(1);
      end
      if (cactus_cond)    cactus_d = 1'b1;
      else if (bird_cond) bird_d   = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_STARTING;
      ret_q        <= ST_PLAYING;
      lives_q      <= LIVES_W'(LIVES);
      speed_q      <= '0;
      frame_q      <= '0;
      tick_q       <= '0;
      inv_q        <= '0;
      start_prev_q <= 1'b1;
      pause_prev_q <= 1'b1;
      score_en_q   <= 1'b0;
      score_clr_q  <= 1'b0;
      bird_q       <= 1'b0;
      cactus_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      ret_q        <= ret_d;
      lives_q      <= lives_d;
      speed_q      <= speed_d;
      frame_q      <= frame_d;
      tick_q       <= tick_d;
      inv_q        <= inv_d;
      start_prev_q <= start_prev_d;
      pause_prev_q <= pause_prev_d;
      score_en_q   <= score_en_d;
      score_clr_q  <= score_clr_d;
      bird_q       <= bird_d;
      cactus_q     <= cactus_d;
    end
  end

  assign bus.state_o        = state_q;
  assign bus.title_en_o     = (state_q == ST_STARTING);
  assign bus.hit_o          = (state_q == ST_HIT) || (state_q == ST_GAME_OVER);
  assign bus.lfsr_next_o    = (state_q == ST_STARTING) || (state_q == ST_PLAYING) ||
                              (state_q == ST_HIT);
  assign bus.score_en_o     = score_en_q;
  assign bus.score_clr_o    = score_clr_q;
  assign bus.bird_spawn_o   = bird_q;
  assign bus.cactus_spawn_o = cactus_q;
  assign bus.lives_o        = lives_q;
  assign bus.speed_o        = speed_q;
endmodule
